// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial LSB-first unsigned subtractor (diff = a - b), one bit
//            per clock through a single full-subtractor cell. Optional macro
//            SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             w_load;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell operating on the current LSBs.
    assign w_d        = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign w_load     = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == RUN) && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (r_cnt == C_LAST) w_next_state = DONE;
            DONE:    w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_load) begin
            r_sa  <= a;
            r_sb  <= b;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_res <= w_res_next;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_br_next;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_a_sign;
    logic r_b_sign;
    logic r_ovf;

    // Sign bits must be captured at load since the operand registers shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sign <= a[WIDTH-1];
                r_b_sign <= b[WIDTH-1];
            end
            if (w_last) begin
                r_ovf <= (r_a_sign != r_b_sign) && (w_d != r_a_sign);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen, bounded; reports edges taken and busy cycles.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cyc++;
            step();
            edges++;
        end
    endtask

    task automatic op(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] dexp, input logic bexp, input string tag);
        int lat;
        int bc;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        wait_done(lat, bc);
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_busy_cycles"}, bc, 8);
        chk({tag, "_diff"}, diff, dexp);
        chk({tag, "_bout"}, bout, bexp);
        chk({tag, "_busy_at_done"}, busy, 0);
        step();
        chk({tag, "_done_pulse_width"}, done, 0);
        chk({tag, "_diff_hold"}, diff, dexp);
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        logic [7:0] seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        step();
        step();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_bout", bout, 0);

        op(8'd100, 8'd37, 8'h3F, 1'b0, "op_100_37");
        op(8'h05, 8'h0A, 8'hFB, 1'b1, "op_05_0A");
        op(8'h00, 8'h01, 8'hFF, 1'b1, "op_00_01");
        op(8'hA5, 8'hA5, 8'h00, 1'b0, "op_equal");

        // Back-to-back with start held high throughout.
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        step();
        wait_done(lat, bc);
        chk("b2b_first_latency", lat, 8);
        chk("b2b_first_diff", diff, 8'h0F);
        a = 8'h20;
        b = 8'h02;
        step();
        chk("b2b_no_idle_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        wait_done(lat, bc);
        chk("b2b_done_spacing", lat + 1, 9);
        chk("b2b_second_diff", diff, 8'h1E);
        start = 1'b0;
        step();
        chk("b2b_back_to_idle", busy, 0);

        // A start pulse during RUN must be ignored.
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        step();
        start  = 1'b0;
        a      = 8'h00;
        pulses = 0;
        seen   = 8'h00;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) begin
                pulses++;
                seen = diff;
            end
            step();
        end
        chk("ignore_start_pulses", pulses, 1);
        chk("ignore_start_diff", seen, 8'h22);

        // Reset mid-RUN aborts the operation and clears the result.
        a     = 8'h50;
        b     = 8'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        chk("abort_no_done", pulses, 0);
        op(8'h09, 8'h04, 8'h05, 1'b0, "op_after_abort");

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        op(8'h80, 8'h01, 8'h7F, 1'b0, "ovf_80_01");
        chk("ovf_80_01_ovf", ovf, 1);
        op(8'h7F, 8'hFF, 8'h80, 1'b1, "ovf_7F_FF");
        chk("ovf_7F_FF_ovf", ovf, 1);
        op(8'h05, 8'h03, 8'h02, 1'b0, "ovf_05_03");
        chk("ovf_05_03_ovf", ovf, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
